sram_access_arbiter: RTL and testbench

Sequences every access to the single 512Kx8 SRAM and shares it between three requesters: the acquisition writer (DiscReader), a disc-write playback reader, and the MCU host data port (register 0x03 read/write). It generates the SRAM WE_n/OE_n strobes, data-bus drive enable and read-data capture. It pulses the external AddressCounter increment once per completed access. It replaces the ad-hoc MWC write state machine and the separate read-increment path.

---
 rtl/sram_access_arbiter_pkg.sv | 27 ++
 rtl/sram_rr_pick.sv | 27 ++
 rtl/sram_access_arbiter.sv | 175 +++++++++++++++++
 tb/tb_sram_access_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_access_arbiter_pkg.sv
// Shared encodings for the SRAM access arbiter: bus owner codes, sequencer
// states and the strobe-timing counter width helper.
package sram_access_arbiter_pkg;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_ACQ  = 2'd1,
      GNT_PB   = 2'd2,
      GNT_MCU  = 2'd3
   } grant_e;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WR_SETUP = 3'd1,
      ST_WR_PULSE = 3'd2,
      ST_RD_WAIT  = 3'd3,
      ST_COMPLETE = 3'd4
   } state_e;

   // Counter only has to reach (cycles-1) of the longer strobe phase.
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/sram_rr_pick.sv
// Two-way round-robin choice between playback and MCU; whichever of the two
// was served last loses a tie. Reset leaves playback preferred.
module sram_rr_pick
   import sram_access_arbiter_pkg::*;
(
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_req_pb,
   input  logic i_req_mcu,
   input  logic i_upd,
   input  logic i_served_mcu,
   output logic o_pick_mcu
);

   logic r_last_mcu;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_last_mcu <= 1'b1;
      end else if (i_upd) begin
         r_last_mcu <= i_served_mcu;
      end
   end

   assign o_pick_mcu = i_req_mcu && (!i_req_pb || !r_last_mcu);

endmodule

// File: rtl/sram_access_arbiter.sv
// Sequences every SRAM access (strobes, data drive, read capture, address
// increment) and arbitrates acquisition, playback and MCU requesters.
module sram_access_arbiter
   import sram_access_arbiter_pkg::*;
#(
   parameter int WR_PULSE_CYCLES = 1,
   parameter int RD_WAIT_CYCLES  = 2
)(
   input  logic       CLOCK,
   input  logic       RESET,
   input  logic       ACQ_REQ,
   input  logic [7:0] ACQ_DATA,
   output logic       ACQ_ACK,
   input  logic       PB_REQ,
   output logic [7:0] PB_RDATA,
   output logic       PB_ACK,
   input  logic       MCU_REQ,
   input  logic       MCU_WR,
   input  logic [7:0] MCU_WDATA,
   output logic [7:0] MCU_RDATA,
   output logic       MCU_ACK,
   output logic [7:0] SRAM_DQ_OUT,
   output logic       SRAM_DQ_OE,
   input  logic [7:0] SRAM_DQ_IN,
   output logic       SRAM_WE_n,
   output logic       SRAM_OE_n,
   output logic       ADDR_INC,
   output logic       BUSY,
   output logic [1:0] GRANT
);

   localparam int              CNT_W   = cnt_width(WR_PULSE_CYCLES, RD_WAIT_CYCLES);
   localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_WAIT_CYCLES - 1);

   state_e           r_state,  w_state_nxt;
   logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
   grant_e           r_grant,  w_grant_nxt;
   logic             r_is_wr,  w_is_wr_nxt;
   logic [7:0]       r_dq_out, w_dq_out_nxt;

   logic r_we_n, r_oe_n, r_dq_oe, r_addr_inc, r_busy;
   logic r_acq_ack, r_pb_ack, r_mcu_ack;
   logic w_we_n_nxt, w_oe_n_nxt, w_dq_oe_nxt, w_done_nxt, w_busy_nxt;
   logic [7:0] r_pb_rdata, r_mcu_rdata;
   logic w_pick_mcu, w_rr_upd, w_served_mcu, w_capture;

   assign w_served_mcu = (r_grant == GNT_MCU);

   sram_rr_pick u_rr_pick (
      .i_clk        (CLOCK),
      .i_rst        (RESET),
      .i_req_pb     (PB_REQ),
      .i_req_mcu    (MCU_REQ),
      .i_upd        (w_rr_upd),
      .i_served_mcu (w_served_mcu),
      .o_pick_mcu   (w_pick_mcu)
   );

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_grant_nxt  = r_grant;
      w_is_wr_nxt  = r_is_wr;
      w_dq_out_nxt = r_dq_out;
      w_rr_upd     = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_cnt_nxt = '0;
            if (ACQ_REQ) begin
               w_grant_nxt  = GNT_ACQ;
               w_is_wr_nxt  = 1'b1;
               w_dq_out_nxt = ACQ_DATA;
               w_state_nxt  = ST_WR_SETUP;
            end else if (PB_REQ || MCU_REQ) begin
               if (w_pick_mcu) begin
                  w_grant_nxt = GNT_MCU;
                  w_is_wr_nxt = MCU_WR;
                  if (MCU_WR) begin
                     w_dq_out_nxt = MCU_WDATA;
                     w_state_nxt  = ST_WR_SETUP;
                  end else begin
                     w_state_nxt  = ST_RD_WAIT;
                  end
               end else begin
                  w_grant_nxt = GNT_PB;
                  w_is_wr_nxt = 1'b0;
                  w_state_nxt = ST_RD_WAIT;
               end
            end
         end
         ST_WR_SETUP: begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_WR_PULSE;
         end
         ST_WR_PULSE: begin
            if (r_cnt == WR_LAST) w_state_nxt = ST_COMPLETE;
            else                  w_cnt_nxt   = r_cnt + 1'b1;
         end
         ST_RD_WAIT: begin
            if (r_cnt == RD_LAST) w_state_nxt = ST_COMPLETE;
            else                  w_cnt_nxt   = r_cnt + 1'b1;
         end
         ST_COMPLETE: begin
            w_rr_upd    = (r_grant == GNT_PB) || (r_grant == GNT_MCU);
            w_grant_nxt = GNT_NONE;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_grant_nxt = GNT_NONE;
            w_state_nxt = ST_IDLE;
         end
      endcase

      // Outputs are registered, so they are decoded from the state being entered.
      w_we_n_nxt  = (w_state_nxt != ST_WR_PULSE);
      w_oe_n_nxt  = (w_state_nxt != ST_RD_WAIT);
      w_dq_oe_nxt = (w_state_nxt == ST_WR_SETUP) || (w_state_nxt == ST_WR_PULSE) ||
                    ((w_state_nxt == ST_COMPLETE) && w_is_wr_nxt);
      w_done_nxt  = (w_state_nxt == ST_COMPLETE);
      w_busy_nxt  = (w_state_nxt != ST_IDLE);
      w_capture   = (r_state == ST_RD_WAIT) && (w_state_nxt == ST_COMPLETE);
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_grant     <= GNT_NONE;
         r_is_wr     <= 1'b0;
         r_dq_out    <= 8'h00;
         r_we_n      <= 1'b1;
         r_oe_n      <= 1'b1;
         r_dq_oe     <= 1'b0;
         r_addr_inc  <= 1'b0;
         r_busy      <= 1'b0;
         r_acq_ack   <= 1'b0;
         r_pb_ack    <= 1'b0;
         r_mcu_ack   <= 1'b0;
         r_pb_rdata  <= 8'h00;
         r_mcu_rdata <= 8'h00;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_grant    <= w_grant_nxt;
         r_is_wr    <= w_is_wr_nxt;
         r_dq_out   <= w_dq_out_nxt;
         r_we_n     <= w_we_n_nxt;
         r_oe_n     <= w_oe_n_nxt;
         r_dq_oe    <= w_dq_oe_nxt;
         r_addr_inc <= w_done_nxt;
         r_busy     <= w_busy_nxt;
         r_acq_ack  <= w_done_nxt && (w_grant_nxt == GNT_ACQ);
         r_pb_ack   <= w_done_nxt && (w_grant_nxt == GNT_PB);
         r_mcu_ack  <= w_done_nxt && (w_grant_nxt == GNT_MCU);
         if (w_capture && (r_grant == GNT_PB))  r_pb_rdata  <= SRAM_DQ_IN;
         if (w_capture && (r_grant == GNT_MCU)) r_mcu_rdata <= SRAM_DQ_IN;
      end
   end

   assign ACQ_ACK     = r_acq_ack;
   assign PB_ACK      = r_pb_ack;
   assign MCU_ACK     = r_mcu_ack;
   assign PB_RDATA    = r_pb_rdata;
   assign MCU_RDATA   = r_mcu_rdata;
   assign SRAM_DQ_OUT = r_dq_out;
   assign SRAM_DQ_OE  = r_dq_oe;
   assign SRAM_WE_n   = r_we_n;
   assign SRAM_OE_n   = r_oe_n;
   assign ADDR_INC    = r_addr_inc;
   assign BUSY        = r_busy;
   assign GRANT       = r_grant;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Bench for sram_access_arbiter: SRAM and address-counter model plus a
// transaction-level reference for arbitration, strobe timing and data.
module tb_sram_access_arbiter;

   localparam int N = 1;  // write pulse cycles
   localparam int M = 2;  // read wait cycles

   logic       CLOCK = 1'b0;
   logic       RESET = 1'b1;
   logic       ACQ_REQ = 1'b0;
   logic [7:0] ACQ_DATA = 8'h00;
   logic       ACQ_ACK;
   logic       PB_REQ = 1'b0;
   logic [7:0] PB_RDATA;
   logic       PB_ACK;
   logic       MCU_REQ = 1'b0;
   logic       MCU_WR = 1'b0;
   logic [7:0] MCU_WDATA = 8'h00;
   logic [7:0] MCU_RDATA;
   logic       MCU_ACK;
   logic [7:0] SRAM_DQ_OUT;
   logic       SRAM_DQ_OE;
   logic [7:0] SRAM_DQ_IN;
   logic       SRAM_WE_n;
   logic       SRAM_OE_n;
   logic       ADDR_INC;
   logic       BUSY;
   logic [1:0] GRANT;

   int         checks = 0;
   int         errs   = 0;
   bit         last_mcu = 1'b1;
   logic [9:0] baddr = '0;
   logic [9:0] ref_addr = '0;
   logic [7:0] sram    [1024];
   logic [7:0] ref_mem [1024];
   logic [7:0] pb_exp  = 8'h00;
   logic [7:0] mcu_exp = 8'h00;

   sram_access_arbiter #(.WR_PULSE_CYCLES(N), .RD_WAIT_CYCLES(M)) dut (
      .CLOCK(CLOCK), .RESET(RESET),
      .ACQ_REQ(ACQ_REQ), .ACQ_DATA(ACQ_DATA), .ACQ_ACK(ACQ_ACK),
      .PB_REQ(PB_REQ), .PB_RDATA(PB_RDATA), .PB_ACK(PB_ACK),
      .MCU_REQ(MCU_REQ), .MCU_WR(MCU_WR), .MCU_WDATA(MCU_WDATA),
      .MCU_RDATA(MCU_RDATA), .MCU_ACK(MCU_ACK),
      .SRAM_DQ_OUT(SRAM_DQ_OUT), .SRAM_DQ_OE(SRAM_DQ_OE), .SRAM_DQ_IN(SRAM_DQ_IN),
      .SRAM_WE_n(SRAM_WE_n), .SRAM_OE_n(SRAM_OE_n),
      .ADDR_INC(ADDR_INC), .BUSY(BUSY), .GRANT(GRANT)
   );

   always #5 CLOCK = ~CLOCK;

   // Undriven bus reads back as 0xEE so an early or late capture is visible.
   assign SRAM_DQ_IN = !SRAM_OE_n ? sram[baddr] : 8'hEE;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock; the SRAM cell and external address counter react to the edge.
   task automatic tick();
      logic       pw;
      logic       pinc;
      logic [7:0] pd;
      pw   = (SRAM_WE_n === 1'b0) && (SRAM_DQ_OE === 1'b1);
      pd   = SRAM_DQ_OUT;
      pinc = (ADDR_INC === 1'b1);
      @(posedge CLOCK);
      #1;
      if (pw)   sram[baddr] = pd;
      if (pinc) baddr = baddr + 10'd1;
   endtask

   task automatic bus_rules();
      chk("no_contention", {31'd0, SRAM_DQ_OE && !SRAM_OE_n}, 32'd0);
      chk("we_needs_dq_oe", {31'd0, !SRAM_WE_n && !SRAM_DQ_OE}, 32'd0);
   endtask

   task automatic idle_step();
      tick();
      chk("idle_busy", BUSY, 0);
      chk("idle_grant", GRANT, 0);
      chk("idle_we_n", SRAM_WE_n, 1);
      chk("idle_oe_n", SRAM_OE_n, 1);
      chk("idle_dq_oe", SRAM_DQ_OE, 0);
      chk("idle_acks", {ACQ_ACK, PB_ACK, MCU_ACK}, 0);
      chk("idle_addr_inc", ADDR_INC, 0);
      bus_rules();
   endtask

   // One whole access from an observed IDLE cycle with the current requests.
   task automatic serve_one(input int raise_k, input bit perturb,
                            output int w, output logic [1:0] g_obs);
      bit         is_wr;
      logic [7:0] data;
      int         len;
      g_obs = 2'd0;
      if (ACQ_REQ)                 w = 1;
      else if (PB_REQ && MCU_REQ)  w = last_mcu ? 2 : 3;
      else if (PB_REQ)             w = 2;
      else if (MCU_REQ)            w = 3;
      else                         w = 0;
      if (w == 0) return;
      is_wr = (w == 1) || ((w == 3) && MCU_WR);
      data  = (w == 1) ? ACQ_DATA : MCU_WDATA;
      if (is_wr) ref_mem[ref_addr] = data;
      len = is_wr ? N + 2 : M + 1;
      for (int k = 1; k <= len; k++) begin
         tick();
         if (k == 1) g_obs = GRANT;
         if (k == len) begin
            if (!is_wr && w == 2) pb_exp  = ref_mem[ref_addr];
            if (!is_wr && w == 3) mcu_exp = ref_mem[ref_addr];
            if (w != 1) last_mcu = (w == 3);
            chk("addr_track", baddr, ref_addr);
            ref_addr = ref_addr + 10'd1;
         end
         chk("busy", BUSY, 1);
         chk("grant", GRANT, w);
         chk("we_n", SRAM_WE_n, !(is_wr && k >= 2 && k <= N + 1));
         chk("oe_n", SRAM_OE_n, !(!is_wr && k <= M));
         chk("dq_oe", SRAM_DQ_OE, is_wr);
         if (is_wr) chk("dq_out", SRAM_DQ_OUT, data);
         chk("acq_ack", ACQ_ACK, (k == len) && (w == 1));
         chk("pb_ack", PB_ACK, (k == len) && (w == 2));
         chk("mcu_ack", MCU_ACK, (k == len) && (w == 3));
         chk("addr_inc", ADDR_INC, k == len);
         chk("pb_rdata", PB_RDATA, pb_exp);
         chk("mcu_rdata", MCU_RDATA, mcu_exp);
         bus_rules();
         if (k == raise_k) begin
            ACQ_REQ = 1'b1;
            PB_REQ  = 1'b1;
         end
         if (perturb && w == 3) begin
            MCU_WR    = 1'($urandom_range(0, 1));
            MCU_WDATA = 8'($urandom);
         end else if (perturb && w == 1) begin
            ACQ_DATA  = 8'($urandom);
         end
      end
   endtask

   initial begin
      int         w;
      logic [1:0] g;
      logic [9:0] saved;
      int         exp_seq [4];
      exp_seq = '{2, 3, 2, 3};

      for (int i = 0; i < 1024; i++) begin
         sram[i]    = 8'($urandom);
         ref_mem[i] = sram[i];
      end

      // Reset values
      tick();
      tick();
      chk("rst_we_n", SRAM_WE_n, 1);
      chk("rst_oe_n", SRAM_OE_n, 1);
      chk("rst_dq_oe", SRAM_DQ_OE, 0);
      chk("rst_dq_out", SRAM_DQ_OUT, 0);
      chk("rst_acks", {ACQ_ACK, PB_ACK, MCU_ACK, ADDR_INC}, 0);
      chk("rst_busy_grant", {BUSY, GRANT}, 0);
      chk("rst_rdata", {PB_RDATA, MCU_RDATA}, 0);
      RESET = 1'b0;
      idle_step();

      // Single acquisition write
      ACQ_REQ = 1'b1; ACQ_DATA = 8'hA5;
      serve_one(0, 1'b0, w, g);
      chk("acq_single_grant", g, 1);
      ACQ_REQ = 1'b0;
      idle_step();

      // MCU read of a known byte
      sram[baddr] = 8'h3C; ref_mem[ref_addr] = 8'h3C;
      MCU_REQ = 1'b1; MCU_WR = 1'b0;
      serve_one(0, 1'b0, w, g);
      chk("mcu_rd_3c", MCU_RDATA, 8'h3C);
      MCU_REQ = 1'b0;
      idle_step();

      // PB and MCU both held: alternate, four increments
      saved = baddr;
      PB_REQ = 1'b1; MCU_REQ = 1'b1; MCU_WR = 1'b0;
      for (int i = 0; i < 4; i++) begin
         serve_one(0, 1'b0, w, g);
         chk("rr_seq", g, exp_seq[i]);
         if (i == 3) begin PB_REQ = 1'b0; MCU_REQ = 1'b0; end
         idle_step();
      end
      chk("rr_inc_count", 10'(baddr - saved), 4);

      // ACQ and PB arrive during an MCU write pulse
      MCU_REQ = 1'b1; MCU_WR = 1'b1; MCU_WDATA = 8'h5A;
      serve_one(2, 1'b0, w, g);
      chk("mcu_first", g, 3);
      MCU_REQ = 1'b0;
      idle_step();
      ACQ_DATA = 8'h96;
      serve_one(0, 1'b0, w, g);
      chk("acq_beats_pb", g, 1);
      ACQ_REQ = 1'b0;
      idle_step();
      serve_one(0, 1'b0, w, g);
      chk("pb_after_acq", g, 2);
      PB_REQ = 1'b0;
      idle_step();

      // Reset during the write pulse aborts without ACK or increment
      MCU_REQ = 1'b1; MCU_WR = 1'b1; MCU_WDATA = 8'hC3;
      ref_mem[ref_addr] = 8'hC3;
      saved = baddr;
      tick();
      chk("abort_k1_dq_oe", SRAM_DQ_OE, 1);
      tick();
      chk("abort_k2_we_n", SRAM_WE_n, 0);
      RESET = 1'b1; MCU_REQ = 1'b0;
      tick();
      chk("abort_we_n", SRAM_WE_n, 1);
      chk("abort_dq_oe", SRAM_DQ_OE, 0);
      chk("abort_busy", BUSY, 0);
      chk("abort_grant", GRANT, 0);
      chk("abort_acks", {ACQ_ACK, PB_ACK, MCU_ACK, ADDR_INC}, 0);
      chk("abort_dq_out", SRAM_DQ_OUT, 0);
      RESET = 1'b0; last_mcu = 1'b1;
      pb_exp = 8'h00; mcu_exp = 8'h00;
      idle_step();
      chk("abort_no_inc", baddr, saved);

      // ACQ streams ten writes while PB waits
      ACQ_REQ = 1'b1; PB_REQ = 1'b1;
      for (int i = 0; i < 10; i++) begin
         ACQ_DATA = 8'($urandom);
         serve_one(0, 1'b0, w, g);
         chk("acq_stream", g, 1);
         if (i == 9) ACQ_REQ = 1'b0;
         idle_step();
      end
      serve_one(0, 1'b0, w, g);
      chk("pb_after_stream", g, 2);
      PB_REQ = 1'b0;
      idle_step();

      // Randomised request mixes
      for (int r = 0; r < 30; r++) begin
         ACQ_REQ   = ($urandom_range(0, 3) == 0);
         PB_REQ    = 1'($urandom_range(0, 1));
         MCU_REQ   = 1'($urandom_range(0, 1));
         if (!ACQ_REQ && !PB_REQ && !MCU_REQ) MCU_REQ = 1'b1;
         ACQ_DATA  = 8'($urandom);
         MCU_WR    = 1'($urandom_range(0, 1));
         MCU_WDATA = 8'($urandom);
         for (int s = 0; s < 12 && (ACQ_REQ || PB_REQ || MCU_REQ); s++) begin
            serve_one(0, 1'b1, w, g);
            case (w)
               1: ACQ_REQ = ($urandom_range(0, 4) == 0);
               2: PB_REQ  = 1'b0;
               3: MCU_REQ = 1'b0;
               default: ;
            endcase
            if (w == 1 && ACQ_REQ) ACQ_DATA = 8'($urandom);
            if (!MCU_REQ && $urandom_range(0, 3) == 0) begin
               MCU_REQ   = 1'b1;
               MCU_WR    = 1'($urandom_range(0, 1));
               MCU_WDATA = 8'($urandom);
            end
            if (!PB_REQ && $urandom_range(0, 3) == 0) PB_REQ = 1'b1;
            idle_step();
         end
         ACQ_REQ = 1'b0; PB_REQ = 1'b0; MCU_REQ = 1'b0;
         idle_step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errs);
      $finish;
   end

endmodule
